// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: the shift-mode
// encodings and the helper that picks the fill bit for right shifts.
package barrel_pkg;

    localparam int MODE_W = 3;

    // Encodings 101 and 110 are not listed here. They fall through to
    // pass-through wherever a mode is decoded.
    typedef enum logic [MODE_W-1:0] {
        MODE_SLL  = 3'b000,
        MODE_SRL  = 3'b001,
        MODE_SRA  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_PASS = 3'b111
    } shift_mode_e;

    // Only arithmetic right shifts replicate the operand's sign bit.
    // Every other mode fills with zero.
    function automatic logic fill_bit(input logic [MODE_W-1:0] mode, input logic msb);
        return (mode == MODE_SRA) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage of the barrel shifter. The stage conditionally
// shifts or rotates its operand by 2^K, then registers the result
// together with the shift amount, mode, fill bit and valid flag that
// travel down the pipe.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int K     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              in_fill,
    input  logic              adv_next,
    output logic              adv,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic [AMT_W-1:0]  amt,
    output logic [MODE_W-1:0] mode,
    output logic              fill
);

    localparam int SH = 2 ** K;

    logic [WIDTH-1:0] step;

    // The stage can load when it holds nothing, or when its contents move
    // on this cycle. Empty slots therefore never block upstream stages.
    assign adv = !valid || adv_next;

    // Apply this stage's 2^K step when its bit of the shift amount is set.
    always_comb begin
        step = in_data;
        if (in_amt[K]) begin
            case (in_mode)
                MODE_SLL: step = in_data << SH;
                MODE_SRL: step = in_data >> SH;
                MODE_SRA: step = (in_data >> SH) | ({WIDTH{in_fill}} & ~({WIDTH{1'b1}} >> SH));
                MODE_ROL: step = (in_data << SH) | (in_data >> (WIDTH - SH));
                MODE_ROR: step = (in_data >> SH) | (in_data << (WIDTH - SH));
                default:  step = in_data;
            endcase
        end
    end

    // Stage register: capture the stepped operand and its side-band whenever the stage advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            mode  <= '0;
            fill  <= 1'b0;
        end else if (adv) begin
            valid <= in_valid;
            data  <= step;
            amt   <= in_amt;
            mode  <= in_mode;
            fill  <= in_fill;
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter with valid/ready flow control on both sides.
// STAGES binary-weighted stages are chained in a generate loop. The
// per-stage advance signals form a ripple chain from out_ready back to
// in_ready.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AMT_W  = $clog2(WIDTH),
    parameter int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [AMT_W-1:0]  shift_amount,
    input  logic [MODE_W-1:0] mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              zero,
    output logic              out_valid,
    input  logic              out_ready
);

    // Index 0 holds the input port values. Index k+1 holds the register
    // outputs of stage k.
    logic [STAGES:0]   valid_c;
    logic [STAGES:0]   adv_c;
    logic [STAGES:0]   fill_c;
    logic [WIDTH-1:0]  data_c [STAGES+1];
    logic [AMT_W-1:0]  amt_c  [STAGES+1];
    logic [MODE_W-1:0] mode_c [STAGES+1];

    assign valid_c[0] = in_valid;
    assign data_c[0]  = data_in;
    assign amt_c[0]   = shift_amount;
    assign mode_c[0]  = mode;
    // Sample the sign bit once, at entry, so every later stage uses the original operand's MSB.
    assign fill_c[0]  = fill_bit(mode, data_in[WIDTH-1]);

    assign adv_c[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .in_valid (valid_c[k]),
            .in_data  (data_c[k]),
            .in_amt   (amt_c[k]),
            .in_mode  (mode_c[k]),
            .in_fill  (fill_c[k]),
            .adv_next (adv_c[k+1]),
            .adv      (adv_c[k]),
            .valid    (valid_c[k+1]),
            .data     (data_c[k+1]),
            .amt      (amt_c[k+1]),
            .mode     (mode_c[k+1]),
            .fill     (fill_c[k+1])
        );
    end

    assign in_ready  = adv_c[0];
    assign out_valid = valid_c[STAGES];
    assign data_out  = data_c[STAGES];
    assign zero      = (data_c[STAGES] == '0);

    // After the last stage, the side-band fields have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_c[STAGES], mode_c[STAGES], fill_c[STAGES]};

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Parametrised, pipelined barrel shifter with five shift modes and valid/ready flow control on both sides. It is the successor to the fixed 4-bit left-shift register. It accepts one operand per cycle and returns the shifted result after a fixed pipeline latency. Stalls are propagated backwards without dropping or duplicating data. It sits in the datapath between operand sources and downstream registers wherever a variable shift or rotate is needed.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, minimum 4
- AMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- STAGES, $clog2(WIDTH), pipeline depth (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state immediately
- data_in  in  WIDTH  operand
- shift_amount  in  AMT_W  shift distance, 0..WIDTH-1
- mode  in  3  shift mode (see Operation)
- in_valid  in  1  operand/amount/mode valid this cycle
- in_ready  out  1  pipeline can accept this cycle
- data_out  out  WIDTH  result
- zero  out  1  data_out == 0
- out_valid  out  1  data_out/zero valid
- out_ready  in  1  downstream accepts this cycle

## Operation
Mode encodings:
- 000 SLL: logical left shift, zero fill
- 001 SRL: logical right shift, zero fill
- 010 SRA: arithmetic right shift, fill with data_in[WIDTH-1]
- 011 ROL: rotate left
- 100 ROR: rotate right
- 101–111: pass-through (data_out = data_in)

Datapath:
- Stage k (k = 0..STAGES-1) shifts/rotates by 2^k when shift_amount[k] = 1, otherwise passes data through unchanged.
- Each stage ends in a register holding data, the remaining amount bits, mode, the SRA fill bit and a valid bit.
- shift_amount = 0 in any mode passes data through unchanged.
- All arithmetic is WIDTH bits; bits shifted out are discarded.
- zero is computed combinationally from the last stage's data register.

Flow control (per stage):
- adv[k] = !valid[k] || adv[k+1], with adv[STAGES] = out_ready.
- Stage k loads from stage k-1 (or from the input when k = 0) when adv[k] is true.
- in_ready = adv[0].
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.
- Bubbles collapse: a downstream stall does not block upstream stages that hold invalid slots.
- The stage data register of a slot loaded with valid = 0 may change freely; data_out is a don't-care while out_valid = 0.

Reset values:
- All valid bits, data registers, amount bits and mode registers = 0.
- Hence out_valid = 0, data_out = 0, zero = 1.
- in_ready = 1 (combinational from the valid bits).

## Timing
- Latency: exactly STAGES cycles from an accepted input to out_valid with no stall (3 cycles at WIDTH = 8).
- Throughput: one result per cycle while out_ready stays high.
- in_ready depends combinationally on out_ready (the adv chain). There is no combinational path from in_valid or data_in to any output.
- out_valid held while out_ready = 0: data_out, zero and out_valid stay stable until the transfer occurs.
- Pipeline full with out_ready = 0: in_ready = 0, and inputs presented then are not captured.
- Simultaneous input and output transfer on a full pipe: both occur and the occupancy is unchanged.
- Reset asserted mid-operation: all in-flight data is discarded asynchronously. The first accepted input after deassertion has the normal latency.
- mode and shift_amount are sampled only on input transfer; changes at other times have no effect.

## Structure
Shared package barrel_pkg:
- shift_mode_e enum with the five mode encodings above plus MODE_PASS.
- helper function for the per-stage fill bit.

Sub-module barrel_stage, parametrised by WIDTH and stage index K:
- one 2^K shift/rotate step plus its valid/data register and adv logic.
- Instantiated STAGES times in a generate loop.

The top level holds only the generate chain, the adv chain, in_ready and zero.

## Test plan
All scenarios at WIDTH = 8.
- Reset: assert reset mid-stream with 2 items in flight -> out_valid = 0, data_out = 0x00, zero = 1 immediately. Those items never appear. in_ready = 1 after deassertion.
- Modes, back-to-back at one input per cycle with out_ready = 1:
  - SLL 0xA3 by 3 -> 0x18
  - SRL 0xA3 by 3 -> 0x14
  - SRA 0x90 by 2 -> 0xE4
  - ROL 0x81 by 1 -> 0x03
  - ROR 0x81 by 1 -> 0xC0
  - Results arrive on cycles 3..7 in order.
- Boundaries:
  - Any mode with amount 0 on 0x5A -> 0x5A.
  - SLL 0x01 by 7 -> 0x80.
  - SRA 0x80 by 7 -> 0xFF.
  - Pass-through mode 111 on 0x3C by 5 -> 0x3C.
  - SRL 0x0F by 4 -> 0x00 with zero = 1.
- Backpressure: stream 6 items while holding out_ready = 0 for 5 cycles.
  - in_ready drops after 3 items are accepted.
  - data_out stays stable while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- Bubble collapse: send 1 item, idle 2 cycles, stall output, send 2 more -> all 3 items accepted without an in_ready drop until the pipe is full.
- Random regression: 10k random operands, amounts and modes with random in_valid/out_ready, checked against a reference model by a scoreboard.
